// File: rtl/ddr3_init_engine.sv
// DDR3 power-up sequencer: reset hold, CKE wait, MRS2/3/1/0, ZQCL, then ready.
// Outputs are registered from the state held during the previous cycle.
module ddr3_init_engine #(
  parameter int T_RESET  = 20,
  parameter int T_CKE    = 50,
  parameter int T_XPR    = 10,
  parameter int T_MRD    = 4,
  parameter int T_MOD    = 12,
  parameter int T_ZQINIT = 64,
  parameter logic [12:0] MR0 = 13'h1D70,
  parameter logic [12:0] MR1 = 13'h0008,
  parameter logic [12:0] MR2 = 13'h0028,
  parameter logic [12:0] MR3 = 13'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ready,
  output logic        ddr_reset_bar,
  output logic        cke,
  output logic        cs_bar,
  output logic        ras_bar,
  output logic        cas_bar,
  output logic        we_bar,
  output logic [2:0]  BA,
  output logic [12:0] A,
  output logic        odt
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ZQCL = 4'b0110;

  typedef enum logic [2:0] {
    RST_HOLD, CKE_WAIT, XPR, MRS, MRS_WAIT, ZQCL, ZQ_WAIT, DONE
  } state_t;

  state_t      state_reg;
  logic [15:0] cnt_reg;
  logic [1:0]  k_reg;
  logic [3:0]  cmd_reg;
  logic [2:0]  mrs_ba;
  logic [12:0] mrs_a;

  assign {cs_bar, ras_bar, cas_bar, we_bar} = cmd_reg;
  assign odt = 1'b0;

  // Mode registers are written in the order MR2, MR3, MR1, MR0.
  always_comb begin
    mrs_ba = 3'd0;
    mrs_a  = 13'd0;
    case (k_reg)
      2'd0: begin mrs_ba = 3'd2; mrs_a = MR2; end
      2'd1: begin mrs_ba = 3'd3; mrs_a = MR3; end
      2'd2: begin mrs_ba = 3'd1; mrs_a = MR1; end
      2'd3: begin mrs_ba = 3'd0; mrs_a = MR0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= RST_HOLD;
      cnt_reg       <= 16'(T_RESET - 1);
      k_reg         <= 2'd0;
      ready         <= 1'b0;
      ddr_reset_bar <= 1'b0;
      cke           <= 1'b0;
      cmd_reg       <= CMD_NOP;
      BA            <= 3'd0;
      A             <= 13'd0;
    end else begin
      cmd_reg <= CMD_NOP;
      BA      <= 3'd0;
      A       <= 13'd0;
      case (state_reg)
        RST_HOLD: begin
          ddr_reset_bar <= 1'b0;
          cke           <= 1'b0;
          if (cnt_reg == 16'd0) begin
            state_reg <= CKE_WAIT;
            cnt_reg   <= 16'(T_CKE - 1);
          end else cnt_reg <= cnt_reg - 16'd1;
        end
        CKE_WAIT: begin
          ddr_reset_bar <= 1'b1;
          if (cnt_reg == 16'd0) begin
            state_reg <= XPR;
            cnt_reg   <= 16'(T_XPR - 1);
          end else cnt_reg <= cnt_reg - 16'd1;
        end
        XPR: begin
          cke <= 1'b1;
          if (cnt_reg == 16'd0) state_reg <= MRS;
          else cnt_reg <= cnt_reg - 16'd1;
        end
        MRS: begin
          cmd_reg <= CMD_MRS;
          BA      <= mrs_ba;
          A       <= mrs_a;
          // A one-cycle tMOD leaves no gap between MRS0 and ZQCL.
          if (k_reg == 2'd3 && T_MOD == 1) state_reg <= ZQCL;
          else begin
            state_reg <= MRS_WAIT;
            cnt_reg   <= (k_reg == 2'd3) ? 16'(T_MOD - 2) : 16'(T_MRD - 2);
          end
        end
        MRS_WAIT: begin
          if (cnt_reg == 16'd0) begin
            if (k_reg == 2'd3) state_reg <= ZQCL;
            else begin
              k_reg     <= k_reg + 2'd1;
              state_reg <= MRS;
            end
          end else cnt_reg <= cnt_reg - 16'd1;
        end
        ZQCL: begin
          cmd_reg <= CMD_ZQCL;
          A       <= 13'h0400;
          if (T_ZQINIT == 1) state_reg <= DONE;
          else begin
            state_reg <= ZQ_WAIT;
            cnt_reg   <= 16'(T_ZQINIT - 2);
          end
        end
        ZQ_WAIT: begin
          if (cnt_reg == 16'd0) state_reg <= DONE;
          else cnt_reg <= cnt_reg - 16'd1;
        end
        DONE: begin
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_init_engine.sv
// Directed bench for ddr3_init_engine: default and minimal parameter timelines,
// mid-sequence reset and reset after ready.
module tb_ddr3_init_engine;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic ready, ddr_reset_bar, cke, cs_bar, ras_bar, cas_bar, we_bar, odt;
  logic [2:0]  BA;
  logic [12:0] A;
  logic m_ready, m_ddr_reset_bar, m_cke, m_cs_bar, m_ras_bar, m_cas_bar, m_we_bar, m_odt;
  logic [2:0]  m_BA;
  logic [12:0] m_A;

  ddr3_init_engine dut (
    .clk(clk), .reset(reset), .ready(ready), .ddr_reset_bar(ddr_reset_bar), .cke(cke),
    .cs_bar(cs_bar), .ras_bar(ras_bar), .cas_bar(cas_bar), .we_bar(we_bar),
    .BA(BA), .A(A), .odt(odt)
  );

  ddr3_init_engine #(.T_RESET(1), .T_CKE(1), .T_XPR(1), .T_MRD(2), .T_MOD(1), .T_ZQINIT(1)) dut_min (
    .clk(clk), .reset(reset), .ready(m_ready), .ddr_reset_bar(m_ddr_reset_bar), .cke(m_cke),
    .cs_bar(m_cs_bar), .ras_bar(m_ras_bar), .cas_bar(m_cas_bar), .we_bar(m_we_bar),
    .BA(m_BA), .A(m_A), .odt(m_odt)
  );

  int checks = 0;
  int errors = 0;
  int mrs_seen = 0;
  int zq_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      $error("%s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Default-parameter expectations at cycle n.
  task automatic check_cycle(input int n);
    logic [3:0]  e_cmd;
    logic [2:0]  e_ba;
    logic [12:0] e_a;
    logic [3:0]  cmd;
    e_cmd = 4'b0111; e_ba = 3'd0; e_a = 13'd0;
    case (n)
      80:  begin e_cmd = 4'b0000; e_ba = 3'd2; e_a = 13'h0028; end
      84:  begin e_cmd = 4'b0000; e_ba = 3'd3; e_a = 13'h0000; end
      88:  begin e_cmd = 4'b0000; e_ba = 3'd1; e_a = 13'h0008; end
      92:  begin e_cmd = 4'b0000; e_ba = 3'd0; e_a = 13'h1D70; end
      104: begin e_cmd = 4'b0110; e_ba = 3'd0; e_a = 13'h0400; end
      default: ;
    endcase
    cmd = {cs_bar, ras_bar, cas_bar, we_bar};
    if (cmd == 4'b0000) mrs_seen++;
    if (cmd == 4'b0110) zq_seen++;
    chk($sformatf("rst_bar n=%0d", n), 32'(ddr_reset_bar), 32'(n >= 20));
    chk($sformatf("cke n=%0d", n), 32'(cke), 32'(n >= 70));
    chk($sformatf("ready n=%0d", n), 32'(ready), 32'(n >= 168));
    chk($sformatf("cmd n=%0d", n), 32'(cmd), 32'(e_cmd));
    chk($sformatf("ba n=%0d", n), 32'(BA), 32'(e_ba));
    chk($sformatf("a n=%0d", n), 32'(A), 32'(e_a));
    chk($sformatf("odt n=%0d", n), 32'(odt), 32'd0);
  endtask

  // Minimal-parameter expectations at cycle n.
  task automatic check_min(input int n);
    logic [3:0]  e_cmd;
    logic [2:0]  e_ba;
    logic [12:0] e_a;
    e_cmd = 4'b0111; e_ba = 3'd0; e_a = 13'd0;
    case (n)
      3:  begin e_cmd = 4'b0000; e_ba = 3'd2; e_a = 13'h0028; end
      5:  begin e_cmd = 4'b0000; e_ba = 3'd3; e_a = 13'h0000; end
      7:  begin e_cmd = 4'b0000; e_ba = 3'd1; e_a = 13'h0008; end
      9:  begin e_cmd = 4'b0000; e_ba = 3'd0; e_a = 13'h1D70; end
      10: begin e_cmd = 4'b0110; e_ba = 3'd0; e_a = 13'h0400; end
      default: ;
    endcase
    chk($sformatf("min rst_bar n=%0d", n), 32'(m_ddr_reset_bar), 32'(n >= 1));
    chk($sformatf("min cke n=%0d", n), 32'(m_cke), 32'(n >= 2));
    chk($sformatf("min ready n=%0d", n), 32'(m_ready), 32'(n >= 11));
    chk($sformatf("min cmd n=%0d", n), 32'({m_cs_bar, m_ras_bar, m_cas_bar, m_we_bar}), 32'(e_cmd));
    chk($sformatf("min ba n=%0d", n), 32'(m_BA), 32'(e_ba));
    chk($sformatf("min a n=%0d", n), 32'(m_A), 32'(e_a));
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, " ready"}, 32'(ready), 32'd0);
    chk({tag, " rst_bar"}, 32'(ddr_reset_bar), 32'd0);
    chk({tag, " cke"}, 32'(cke), 32'd0);
    chk({tag, " cmd"}, 32'({cs_bar, ras_bar, cas_bar, we_bar}), 32'h7);
    chk({tag, " ba"}, 32'(BA), 32'd0);
    chk({tag, " a"}, 32'(A), 32'd0);
  endtask

  initial begin
    // Run 1: reset for 3 cycles, full default timeline plus minimal instance.
    reset = 1'b1;
    repeat (3) step();
    check_reset_values("por");
    reset = 1'b0;
    for (int n = 0; n < 200; n++) begin
      step();
      check_cycle(n);
      if (n <= 15) check_min(n);
    end
    chk("run1 mrs count", 32'(mrs_seen), 32'd4);
    chk("run1 zq count", 32'(zq_seen), 32'd1);

    // Reset after ready, asserted at n=200.
    reset = 1'b1;
    step();
    check_reset_values("after ready");
    reset = 1'b0;
    mrs_seen = 0; zq_seen = 0;
    for (int n = 0; n <= 168; n++) begin
      step();
      check_cycle(n);
    end
    chk("run2 mrs count", 32'(mrs_seen), 32'd4);
    chk("run2 zq count", 32'(zq_seen), 32'd1);

    // Reset mid-sequence at n=86, between MRS3 and MRS1.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 86; n++) begin
      step();
      check_cycle(n);
    end
    reset = 1'b1;
    step();
    check_reset_values("mid seq");
    step();
    reset = 1'b0;
    mrs_seen = 0; zq_seen = 0;
    for (int n = 0; n < 200; n++) begin
      step();
      check_cycle(n);
    end
    chk("run3 mrs count", 32'(mrs_seen), 32'd4);
    chk("run3 zq count", 32'(zq_seen), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
